cpu_seq_ctrl: RTL and testbench

Multicycle sequencer for the MIPS CPU core. It generates the `state_t` state consumed by the instruction register, decoder and datapath, and runs the Avalon-style memory handshake for instruction fetch and data access. It stalls on bus wait-states and on the multiply/divide unit, and halts when the PC reaches the halt address. It sits at the top of the core, between the memory bus and the IR/PC/register-file enables.

---
 rtl/cpu_seq_ctrl.sv | 117 +++++++++++
 tb/tb_cpu_seq_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/cpu_seq_ctrl.sv
// Multicycle sequencer for the MIPS core: drives the fetch/exec state and the
// Avalon-style memory handshake. Stalls on bus wait-states and the mult/div unit.
package codes;
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    EXEC1  = 3'd1,
    STALL  = 3'd2,
    EXEC2  = 3'd3,
    HALTED = 3'd4
  } state_t;
endpackage

module cpu_seq_ctrl
  import codes::*;
#(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_i,
  input  logic                   waitrequest_i,
  input  logic                   mem_read_req_i,
  input  logic                   mem_write_req_i,
  input  logic                   mult_busy_i,
  input  logic                   pc_halt_i,
  output state_t                 state_o,
  output logic                   read_o,
  output logic                   write_o,
  output logic                   ir_wen_o,
  output logic                   commit_o,
  output logic                   active_o,
  output logic [COUNT_WIDTH-1:0] instr_count_o
);

  state_t                 state_q, state_nxt;
  logic                   pend_rd_q, pend_wr_q;
  logic [COUNT_WIDTH-1:0] instr_count_q;
  logic                   rd_c, wr_c, irw_c, commit_c, active_c;
  logic                   data_rd_c, data_wr_c;

  // Write wins over read so the two strobes can never be high together.
  assign data_wr_c = mem_write_req_i;
  assign data_rd_c = mem_read_req_i & ~mem_write_req_i;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= FETCH;
      pend_rd_q     <= 1'b0;
      pend_wr_q     <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q <= state_nxt;
      if (state_q == EXEC1) begin
        pend_rd_q <= data_rd_c;
        pend_wr_q <= data_wr_c;
      end
      if (commit_c)
        instr_count_q <= instr_count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_nxt = state_q;
    rd_c      = 1'b0;
    wr_c      = 1'b0;
    irw_c     = 1'b0;
    commit_c  = 1'b0;
    active_c  = 1'b1;
    case (state_q)
      FETCH: begin
        if (pc_halt_i) begin
          state_nxt = HALTED;
        end else begin
          rd_c = 1'b1;
          if (!waitrequest_i)
            state_nxt = EXEC1;
        end
      end
      EXEC1: begin
        irw_c = 1'b1;
        rd_c  = data_rd_c;
        wr_c  = data_wr_c;
        if ((data_rd_c || data_wr_c) && waitrequest_i)
          state_nxt = STALL;
        else
          state_nxt = EXEC2;
      end
      // Strobe kind is held from the EXEC1 latch until the bus accepts it.
      STALL: begin
        rd_c = pend_rd_q;
        wr_c = pend_wr_q;
        if (!waitrequest_i)
          state_nxt = EXEC2;
      end
      EXEC2: begin
        if (!mult_busy_i) begin
          commit_c  = 1'b1;
          state_nxt = FETCH;
        end
      end
      HALTED: begin
        active_c = 1'b0;
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  assign state_o       = state_q;
  assign read_o        = rd_c & ~reset_i;
  assign write_o       = wr_c & ~reset_i;
  assign ir_wen_o      = irw_c & ~reset_i;
  assign commit_o      = commit_c & ~reset_i;
  assign active_o      = active_c;
  assign instr_count_o = instr_count_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: a default-width and a 4-bit-counter instance
// share one stimulus stream; every expected value is written out by hand.
module tb_cpu_seq_ctrl;
  import codes::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_i, waitrequest_i, mem_read_req_i, mem_write_req_i, mult_busy_i, pc_halt_i;

  state_t      st32, st4;
  logic        rd32, wr32, ir32, cm32, ac32;
  logic        rd4, wr4, ir4, cm4, ac4;
  logic [31:0] cnt32;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  cpu_seq_ctrl dut (
    .clk(clk), .reset_i(reset_i), .waitrequest_i(waitrequest_i),
    .mem_read_req_i(mem_read_req_i), .mem_write_req_i(mem_write_req_i),
    .mult_busy_i(mult_busy_i), .pc_halt_i(pc_halt_i),
    .state_o(st32), .read_o(rd32), .write_o(wr32), .ir_wen_o(ir32),
    .commit_o(cm32), .active_o(ac32), .instr_count_o(cnt32)
  );

  cpu_seq_ctrl #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .reset_i(reset_i), .waitrequest_i(waitrequest_i),
    .mem_read_req_i(mem_read_req_i), .mem_write_req_i(mem_write_req_i),
    .mult_busy_i(mult_busy_i), .pc_halt_i(pc_halt_i),
    .state_o(st4), .read_o(rd4), .write_o(wr4), .ir_wen_o(ir4),
    .commit_o(cm4), .active_o(ac4), .instr_count_o(cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic cyc(input string tag, input state_t st, input logic rd, input logic wr,
                     input logic irw, input logic cm, input logic act);
    chk({tag, ".state"},  32'(st32), 32'(st));
    chk({tag, ".read"},   32'(rd32), 32'(rd));
    chk({tag, ".write"},  32'(wr32), 32'(wr));
    chk({tag, ".irwen"},  32'(ir32), 32'(irw));
    chk({tag, ".commit"}, 32'(cm32), 32'(cm));
    chk({tag, ".active"}, 32'(ac32), 32'(act));
    chk({tag, ".state4"}, 32'(st4),  32'(st));
    chk({tag, ".read4"},  32'(rd4),  32'(rd));
    chk({tag, ".write4"}, 32'(wr4),  32'(wr));
    chk({tag, ".irwen4"}, 32'(ir4),  32'(irw));
    chk({tag, ".commit4"},32'(cm4),  32'(cm));
    chk({tag, ".active4"},32'(ac4),  32'(act));
  endtask

  task automatic cnt(input string tag, input int unsigned n);
    chk({tag, ".count"},  cnt32, 32'(n));
    chk({tag, ".count4"}, 32'(cnt4), 32'(n % 16));
  endtask

  initial begin
    reset_i = 1'b1; waitrequest_i = 1'b0; mem_read_req_i = 1'b0;
    mem_write_req_i = 1'b0; mult_busy_i = 1'b0; pc_halt_i = 1'b0;

    // Reset values
    #3;
    cyc("rst", FETCH, 0, 0, 0, 0, 1);
    cnt("rst", 0);

    // ALU instruction, no wait-states
    tick(); tick(); reset_i = 1'b0; settle();
    cyc("alu_f", FETCH, 1, 0, 0, 0, 1);
    tick(); settle(); cyc("alu_e1", EXEC1, 0, 0, 1, 0, 1);
    tick(); settle(); cyc("alu_e2", EXEC2, 0, 0, 0, 1, 1); cnt("alu_e2", 0);
    tick(); settle(); cyc("alu_done", FETCH, 1, 0, 0, 0, 1); cnt("alu_done", 1);

    // Fetch with two wait-states; pc_halt outside FETCH is ignored
    waitrequest_i = 1'b1; settle(); cyc("fw0", FETCH, 1, 0, 0, 0, 1);
    tick(); settle(); cyc("fw1", FETCH, 1, 0, 0, 0, 1);
    tick(); waitrequest_i = 1'b0; settle(); cyc("fw2", FETCH, 1, 0, 0, 0, 1);
    tick(); pc_halt_i = 1'b1; settle(); cyc("fw_e1", EXEC1, 0, 0, 1, 0, 1);
    tick(); settle(); cyc("fw_e2", EXEC2, 0, 0, 0, 1, 1);
    tick(); pc_halt_i = 1'b0; settle(); cyc("fw_done", FETCH, 1, 0, 0, 0, 1); cnt("fw_done", 2);

    // Load with three data wait-states; request input dropped after EXEC1
    tick(); mem_read_req_i = 1'b1; waitrequest_i = 1'b1; settle();
    cyc("ld_e1", EXEC1, 1, 0, 1, 0, 1);
    tick(); mem_read_req_i = 1'b0; settle(); cyc("ld_s1", STALL, 1, 0, 0, 0, 1);
    tick(); settle(); cyc("ld_s2", STALL, 1, 0, 0, 0, 1);
    tick(); waitrequest_i = 1'b0; settle(); cyc("ld_s3", STALL, 1, 0, 0, 0, 1);
    tick(); settle(); cyc("ld_e2", EXEC2, 0, 0, 0, 1, 1);
    tick(); settle(); cyc("ld_done", FETCH, 1, 0, 0, 0, 1); cnt("ld_done", 3);

    // Store with both requests high, bus stall overlapping mult busy, then 4 busy cycles
    tick(); mem_read_req_i = 1'b1; mem_write_req_i = 1'b1; waitrequest_i = 1'b1; settle();
    cyc("st_e1", EXEC1, 0, 1, 1, 0, 1);
    tick(); mem_read_req_i = 1'b0; mem_write_req_i = 1'b0; mult_busy_i = 1'b1; settle();
    cyc("st_s1", STALL, 0, 1, 0, 0, 1);
    tick(); waitrequest_i = 1'b0; settle(); cyc("st_s2", STALL, 0, 1, 0, 0, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      settle(); cyc("mb_busy", EXEC2, 0, 0, 0, 0, 1); cnt("mb_busy", 3);
      tick();
    end
    mult_busy_i = 1'b0; settle(); cyc("mb_go", EXEC2, 0, 0, 0, 1, 1); cnt("mb_go", 3);
    tick(); settle(); cyc("mb_done", FETCH, 1, 0, 0, 0, 1); cnt("mb_done", 4);

    // Asynchronous reset in the middle of STALL
    tick(); mem_read_req_i = 1'b1; waitrequest_i = 1'b1; settle();
    tick(); mem_read_req_i = 1'b0; settle(); cyc("rs_s", STALL, 1, 0, 0, 0, 1);
    #2 reset_i = 1'b1; #1;
    cyc("rs_async", FETCH, 0, 0, 0, 0, 1); cnt("rs_async", 0);
    tick(); cyc("rs_held", FETCH, 0, 0, 0, 0, 1);
    waitrequest_i = 1'b0; reset_i = 1'b0; settle();
    cyc("rs_rel", FETCH, 1, 0, 0, 0, 1);
    tick(); settle(); cyc("rs_e1", EXEC1, 0, 0, 1, 0, 1);
    tick(); settle(); cyc("rs_e2", EXEC2, 0, 0, 0, 1, 1);
    tick(); settle(); cnt("rs_done", 1);

    // Retire up to 17 instructions; 4-bit counter wraps at 16
    for (int i = 2; i <= 17; i++) begin
      tick(); tick(); settle();
      chk("wrap.commit", 32'(cm32), 32'd1);
      tick(); settle();
      cnt("wrap", i);
    end

    // Halt, then 20 cycles of noise on the inputs
    pc_halt_i = 1'b1; settle(); cyc("h_f", FETCH, 0, 0, 0, 0, 1);
    tick(); pc_halt_i = 1'b0; mem_read_req_i = 1'b1; settle();
    for (int i = 0; i < 20; i++) begin
      cyc("halted", HALTED, 0, 0, 0, 0, 0); cnt("halted", 17);
      tick();
      waitrequest_i   = i[0];
      mult_busy_i     = i[1];
      mem_write_req_i = i[2];
      settle();
    end
    reset_i = 1'b1; settle();
    cyc("h_rst", FETCH, 0, 0, 0, 0, 1); cnt("h_rst", 0);
    tick(); reset_i = 1'b0; waitrequest_i = 1'b0; mult_busy_i = 1'b0;
    mem_read_req_i = 1'b0; mem_write_req_i = 1'b0; settle();
    cyc("h_rel", FETCH, 1, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
